// File: rtl/graphics_pkg.sv
// Shared graphics types: screen geometry defaults, pending-write queue entry layout
// and the rectangle-fill FSM state encoding.
package graphics_pkg;

    localparam int unsigned DEFAULT_SCREEN_WIDTH  = 320;
    localparam int unsigned DEFAULT_SCREEN_HEIGHT = 240;

    typedef logic [16:0] pixel_address_t;
    typedef logic [7:0]  pixel_data_t;

    // One pending SRAM write as it travels through the queue to the memory manager.
    typedef struct packed {
        pixel_address_t address;
        pixel_data_t    data;
    } write_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        EMIT,
        DONE
    } rect_fill_state_t;

    function automatic pixel_address_t pixel_address(input logic [8:0] x, input logic [7:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/rect_fill_writer_if.sv
// Command handshake and pending-write queue push port of the rectangle-fill writer.
interface rect_fill_writer_if;

    logic        cmdValid;
    logic        cmdReady;
    logic [8:0]  cmdX;
    logic [7:0]  cmdY;
    logic [8:0]  cmdWidth;
    logic [7:0]  cmdHeight;
    logic [7:0]  cmdColour;
    logic [24:0] pendingWriteQueueWriteBus;
    logic        pendingWriteQueueWriteRequest;
    logic        pendingWriteQueueWriteFull;
    logic        busy;
    logic        done;

    modport slave (
        input  cmdValid, cmdX, cmdY, cmdWidth, cmdHeight, cmdColour,
        input  pendingWriteQueueWriteFull,
        output cmdReady, pendingWriteQueueWriteBus, pendingWriteQueueWriteRequest,
        output busy, done
    );

    modport master (
        output cmdValid, cmdX, cmdY, cmdWidth, cmdHeight, cmdColour,
        output pendingWriteQueueWriteFull,
        input  cmdReady, pendingWriteQueueWriteBus, pendingWriteQueueWriteRequest,
        input  busy, done
    );

endinterface

// File: rtl/rect_fill_writer.sv
// Turns one clipped rectangle-fill command into a row-major stream of {address, data}
// pushes into the pending-write queue, one pixel per clock when the queue has room.
module rect_fill_writer
    import graphics_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
    parameter int unsigned SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT
) (
    input  logic               clock,
    input  logic               resetN,
    rect_fill_writer_if.slave  io
);

    localparam logic [9:0] X_LIMIT = 10'(SCREEN_WIDTH);
    localparam logic [8:0] Y_LIMIT = 9'(SCREEN_HEIGHT);

    rect_fill_state_t state_q, state_d;

    logic [8:0] cmd_x_q,      cmd_x_d;
    logic [7:0] cmd_y_q,      cmd_y_d;
    logic [8:0] cmd_width_q,  cmd_width_d;
    logic [7:0] cmd_height_q, cmd_height_d;
    logic [7:0] colour_q,     colour_d;
    logic [8:0] cur_x_q,      cur_x_d;
    logic [7:0] cur_y_q,      cur_y_d;
    logic [9:0] x_end_q,      x_end_d;
    logic [8:0] y_end_q,      y_end_d;

    logic [9:0]   x_sum;
    logic [8:0]   y_sum;
    logic [9:0]   x_next;
    logic [8:0]   y_next;
    logic         empty_cmd;
    logic         push;
    write_entry_t entry;

    assign push = (state_q == EMIT) && !io.pendingWriteQueueWriteFull;

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        cmd_x_d      = cmd_x_q;
        cmd_y_d      = cmd_y_q;
        cmd_width_d  = cmd_width_q;
        cmd_height_d = cmd_height_q;
        colour_d     = colour_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        x_end_d      = x_end_q;
        y_end_d      = y_end_q;

        x_sum     = {1'b0, cmd_x_q} + {1'b0, cmd_width_q};
        y_sum     = {1'b0, cmd_y_q} + {1'b0, cmd_height_q};
        x_next    = {1'b0, cur_x_q} + 10'd1;
        y_next    = {1'b0, cur_y_q} + 9'd1;
        empty_cmd = (cmd_width_q == '0) || (cmd_height_q == '0) ||
                    ({1'b0, cmd_x_q} >= X_LIMIT) || ({1'b0, cmd_y_q} >= Y_LIMIT);

        case (state_q)
            IDLE: begin
                if (io.cmdValid) begin
                    cmd_x_d      = io.cmdX;
                    cmd_y_d      = io.cmdY;
                    cmd_width_d  = io.cmdWidth;
                    cmd_height_d = io.cmdHeight;
                    colour_d     = io.cmdColour;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                // Clip ends are exclusive bounds, so the pixel count is (end - start) per axis.
                x_end_d = (x_sum > X_LIMIT) ? X_LIMIT : x_sum;
                y_end_d = (y_sum > Y_LIMIT) ? Y_LIMIT : y_sum;
                if (empty_cmd) begin
                    state_d = DONE;
                end else begin
                    cur_x_d = cmd_x_q;
                    cur_y_d = cmd_y_q;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (push) begin
                    if (x_next < x_end_q) begin
                        cur_x_d = x_next[8:0];
                    end else if (y_next == y_end_q) begin
                        state_d = DONE;
                    end else begin
                        cur_x_d = cmd_x_q;
                        cur_y_d = y_next[7:0];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
        if (!resetN) begin
            state_q      <= IDLE;
            cmd_x_q      <= '0;
            cmd_y_q      <= '0;
            cmd_width_q  <= '0;
            cmd_height_q <= '0;
            colour_q     <= '0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            x_end_q      <= '0;
            y_end_q      <= '0;
        end else begin
            state_q      <= state_d;
            cmd_x_q      <= cmd_x_d;
            cmd_y_q      <= cmd_y_d;
            cmd_width_q  <= cmd_width_d;
            cmd_height_q <= cmd_height_d;
            colour_q     <= colour_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            x_end_q      <= x_end_d;
            y_end_q      <= y_end_d;
        end
    end

    // The bus follows the counters directly so a full queue simply holds the same entry.
    always_comb begin
        entry = '0;
        if (state_q == EMIT) begin
            entry.address = pixel_address(cur_x_q, cur_y_q);
            entry.data    = colour_q;
        end
    end

    assign io.pendingWriteQueueWriteBus     = entry;
    assign io.pendingWriteQueueWriteRequest = push;
    assign io.cmdReady                      = (state_q == IDLE);
    assign io.busy                          = (state_q != IDLE);
    assign io.done                          = (state_q == DONE);

endmodule

// File: tb/tb_rect_fill_writer.sv
// Scoreboard bench for rect_fill_writer: a pixel-loop reference model queues expected
// pushes and an independent monitor pops and compares every push the DUT makes.
module tb_rect_fill_writer;

    logic clock = 1'b0;
    logic resetN;
    always #5 clock = ~clock;

    rect_fill_writer_if bus_if();

    rect_fill_writer dut (
        .clock  (clock),
        .resetN (resetN),
        .io     (bus_if)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          pushes_seen = 0;
    int          full_mode   = 0;
    logic [24:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: enumerate every visible pixel of the clipped rectangle, row by row.
    task automatic model_cmd(input int x, input int y, input int w, input int h,
                             input logic [7:0] c, output int n);
        int xe, ye;
        logic [24:0] e;
        xe = (x + w > 320) ? 320 : x + w;
        ye = (y + h > 240) ? 240 : y + h;
        n  = 0;
        if (x < 320 && y < 240) begin
            for (int yy = y; yy < ye; yy++) begin
                for (int xx = x; xx < xe; xx++) begin
                    e = {8'(yy), 9'(xx), c};
                    exp_q.push_back(e);
                    n++;
                end
            end
        end
    endtask

    // Queue-full driver: 0 = never full, 1 = alternate cycles, 2 = random.
    initial begin
        bus_if.pendingWriteQueueWriteFull = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (full_mode)
                1:       bus_if.pendingWriteQueueWriteFull = ~bus_if.pendingWriteQueueWriteFull;
                2:       bus_if.pendingWriteQueueWriteFull = ($urandom_range(0, 2) == 0);
                default: bus_if.pendingWriteQueueWriteFull = 1'b0;
            endcase
        end
    end

    // Monitor: every push must match the head of the scoreboard; a full cycle must not push.
    initial begin
        forever begin
            @(negedge clock);
            if (resetN === 1'b1) begin
                if (bus_if.pendingWriteQueueWriteFull) begin
                    check("no_push_when_full", bus_if.pendingWriteQueueWriteRequest, 0);
                    if (bus_if.pendingWriteQueueWriteBus != '0 && exp_q.size() != 0)
                        check("bus_held_while_full", bus_if.pendingWriteQueueWriteBus, exp_q[0]);
                end else if (bus_if.pendingWriteQueueWriteRequest) begin
                    pushes_seen++;
                    check("push_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0)
                        check("push_entry", bus_if.pendingWriteQueueWriteBus, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_cmd(input int x, input int y, input int w, input int h,
                            input logic [7:0] c, input bit hold);
        int n, first_push, done_cycle;
        bit done_seen;
        model_cmd(x, y, w, h, c, n);
        first_push = 0;
        done_cycle = 0;
        done_seen  = 1'b0;
        @(posedge clock);
        #1;
        bus_if.cmdX      = 9'(x);
        bus_if.cmdY      = 8'(y);
        bus_if.cmdWidth  = 9'(w);
        bus_if.cmdHeight = 8'(h);
        bus_if.cmdColour = c;
        bus_if.cmdValid  = 1'b1;
        @(negedge clock);
        check("ready_before_accept", bus_if.cmdReady, 1);
        @(posedge clock);
        #1;
        bus_if.cmdValid = hold;
        for (int cyc = 1; cyc <= 1000 && !done_seen; cyc++) begin
            @(negedge clock);
            if (bus_if.done) begin
                done_seen       = 1'b1;
                done_cycle      = cyc;
                bus_if.cmdValid = 1'b0;
            end else begin
                check("ready_low_while_busy", bus_if.cmdReady, 0);
                check("busy_high", bus_if.busy, 1);
            end
            if (bus_if.pendingWriteQueueWriteRequest && first_push == 0)
                first_push = cyc;
            if (!done_seen) begin
                @(posedge clock);
                #1;
                if (hold) begin
                    bus_if.cmdX      = 9'($urandom);
                    bus_if.cmdY      = 8'($urandom);
                    bus_if.cmdWidth  = 9'($urandom);
                    bus_if.cmdHeight = 8'($urandom);
                    bus_if.cmdColour = 8'($urandom);
                end
            end
        end
        check("done_seen", done_seen, 1);
        if (n == 0) begin
            check("empty_done_latency", done_cycle, 2);
        end else if (full_mode == 0) begin
            check("first_push_latency", first_push, 2);
            check("done_latency", done_cycle, n + 2);
        end
        check("all_pushes_made", exp_q.size(), 0);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("done_single_pulse", bus_if.done, 0);
        check("idle_not_busy", bus_if.busy, 0);
        check("ready_after_done", bus_if.cmdReady, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rx, ry, rw, rh;
        resetN           = 1'b0;
        bus_if.cmdValid  = 1'b0;
        bus_if.cmdX      = '0;
        bus_if.cmdY      = '0;
        bus_if.cmdWidth  = '0;
        bus_if.cmdHeight = '0;
        bus_if.cmdColour = '0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_ready", bus_if.cmdReady, 1);
        check("reset_request", bus_if.pendingWriteQueueWriteRequest, 0);
        check("reset_bus", bus_if.pendingWriteQueueWriteBus, 0);
        check("reset_busy", bus_if.busy, 0);
        check("reset_done", bus_if.done, 0);
        @(posedge clock);
        #1;
        resetN = 1'b1;

        full_mode = 0;
        send_cmd(10, 5, 3, 2, 8'hAB, 1'b0);
        send_cmd(318, 239, 5, 4, 8'h11, 1'b0);
        send_cmd(10, 10, 0, 3, 8'h33, 1'b0);
        send_cmd(400, 10, 2, 2, 8'h44, 1'b0);
        send_cmd(10, 10, 3, 0, 8'h55, 1'b0);
        send_cmd(5, 240, 3, 3, 8'h66, 1'b0);

        full_mode = 1;
        send_cmd(0, 0, 4, 1, 8'h22, 1'b0);

        full_mode = 0;
        send_cmd(20, 30, 5, 3, 8'h77, 1'b1);

        for (int i = 0; i < 24; i++) begin
            rx = ($urandom_range(0, 3) == 0) ? $urandom_range(300, 330) : $urandom_range(0, 319);
            ry = ($urandom_range(0, 3) == 0) ? $urandom_range(225, 250) : $urandom_range(0, 239);
            rw = $urandom_range(0, 12);
            rh = $urandom_range(0, 5);
            full_mode = $urandom_range(0, 2);
            send_cmd(rx, ry, rw, rh, 8'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a 10-pixel fill.
        full_mode = 0;
        base = pushes_seen;
        begin
            int n;
            model_cmd(0, 10, 10, 1, 8'h5C, n);
        end
        @(posedge clock);
        #1;
        bus_if.cmdX      = 9'd0;
        bus_if.cmdY      = 8'd10;
        bus_if.cmdWidth  = 9'd10;
        bus_if.cmdHeight = 8'd1;
        bus_if.cmdColour = 8'h5C;
        bus_if.cmdValid  = 1'b1;
        @(posedge clock);
        #1;
        bus_if.cmdValid = 1'b0;
        for (int i = 0; i < 50 && pushes_seen < base + 3; i++) begin
            @(negedge clock);
            #1;
        end
        check("pushes_before_reset", pushes_seen - base, 3);
        @(posedge clock);
        #1;
        resetN = 1'b0;
        #1;
        check("midreset_ready", bus_if.cmdReady, 1);
        check("midreset_request", bus_if.pendingWriteQueueWriteRequest, 0);
        check("midreset_bus", bus_if.pendingWriteQueueWriteBus, 0);
        check("midreset_busy", bus_if.busy, 0);
        check("midreset_done", bus_if.done, 0);
        exp_q.delete();
        repeat (3) @(posedge clock);
        #1;
        resetN = 1'b1;
        repeat (20) @(negedge clock);
        check("no_pushes_after_reset", pushes_seen - base, 3);
        check("ready_after_reset", bus_if.cmdReady, 1);
        check("idle_after_reset", bus_if.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
